csidh_result_collector: RTL and testbench

- Downstream stage of the CSIDH top. Consumes the 64-bit word stream carrying the resulting curve coefficient A, least-significant word first.
- Reassembles the stream into an N-bit value and range-checks it against p in constant time (word-serial compare, fixed cycle count).
- Presents the result to the consumer (host/key-exchange controller) over a valid/ready handshake, with an error flag.

---
 rtl/csidh_result_collector.sv | 170 +++++++++++++++++
 tb/tb_csidh_result_collector.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csidh_result_collector.sv
// Collects the LSW-first word stream of curve coefficient A, range-checks it against p
// with a fixed-length word-serial compare, and hands the result over valid/ready.
module csidh_result_collector #(
  parameter int unsigned N = 1024,
  parameter int unsigned W = 64,
  // Default only pins the top word; instantiate with the core's p.
  parameter logic [N-1:0] P = {64'h0ece55ed427012a9, {(N-64){1'b1}}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  input  logic         i_invalid_in,
  output logic         o_key_valid,
  input  logic         i_key_ready,
  output logic [N-1:0] o_key_data,
  output logic         o_key_err,
  output logic         o_busy,
  output logic         o_drop
);

  localparam int unsigned CHUNKS = N / W;
  localparam int unsigned IW     = $clog2(CHUNKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_CMP     = 2'd2,
    S_OUT     = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [W-1:0]  r_words [CHUNKS];
  logic [IW-1:0] r_cnt;
  logic [IW-1:0] r_idx;
  logic          r_lt;
  logic          r_eq;
  logic          r_inv;
  logic          r_key_valid;
  logic          r_key_err;
  logic          r_busy;
  logic          r_drop;

  logic          w_first_beat;
  logic          w_store;
  logic [IW-1:0] w_wr_idx;
  logic          w_last_beat;
  logic          w_cmp_step;
  logic          w_cmp_done;
  logic          w_handshake;
  logic          w_drop;

  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_lt_nxt;
  logic          w_eq_nxt;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (i_in_valid) w_state_nxt = S_COLLECT;
      S_COLLECT: if (i_in_valid && (r_cnt == LAST_IDX)) w_state_nxt = S_CMP;
      S_CMP:     if (r_idx == '0) w_state_nxt = S_OUT;
      S_OUT:     if (i_key_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath controls decoded from state and inputs
  always_comb begin
    w_first_beat = 1'b0;
    w_store      = 1'b0;
    w_wr_idx     = r_cnt;
    w_last_beat  = 1'b0;
    w_cmp_step   = 1'b0;
    w_cmp_done   = 1'b0;
    w_handshake  = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_first_beat = i_in_valid;
        w_store      = i_in_valid;
        w_wr_idx     = '0;
      end
      S_COLLECT: begin
        w_store     = i_in_valid;
        w_last_beat = i_in_valid && (r_cnt == LAST_IDX);
      end
      S_CMP: begin
        w_cmp_step = 1'b1;
        w_cmp_done = (r_idx == '0);
        w_drop     = i_in_valid;
      end
      S_OUT: begin
        w_handshake = i_key_ready;
        w_drop      = i_in_valid;
      end
      default: ;
    endcase
  end

  // One word-pair per cycle, MSW first; lt latches at the first differing word
  assign w_a      = r_words[r_idx];
  assign w_b      = P[r_idx*W +: W];
  assign w_lt_nxt = r_lt | (r_eq & (w_a < w_b));
  assign w_eq_nxt = r_eq & (w_a == w_b);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHUNKS; i++) r_words[i] <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_lt        <= 1'b0;
      r_eq        <= 1'b0;
      r_inv       <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_drop      <= 1'b0;
    end else begin
      if (w_store) r_words[w_wr_idx] <= i_in_data;

      if (w_first_beat) begin
        r_inv <= i_invalid_in;
        r_cnt <= IW'(1);
      end else if (w_store) begin
        r_inv <= r_inv | i_invalid_in;
        r_cnt <= r_cnt + IW'(1);
      end else if (w_handshake) begin
        r_cnt <= '0;
      end

      if (w_last_beat) begin
        r_idx <= LAST_IDX;
        r_eq  <= 1'b1;
        r_lt  <= 1'b0;
      end else if (w_cmp_step) begin
        r_idx <= r_idx - IW'(1);
        r_eq  <= w_eq_nxt;
        r_lt  <= w_lt_nxt;
      end

      if (w_cmp_done) r_key_err <= ~w_lt_nxt | r_inv;

      r_key_valid <= (w_state_nxt == S_OUT);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_drop      <= w_drop;
    end
  end

  for (genvar g = 0; g < CHUNKS; g++) begin : g_pack
    assign o_key_data[g*W +: W] = r_words[g];
  end

  assign o_key_valid = r_key_valid;
  assign o_key_err   = r_key_err;
  assign o_busy      = r_busy;
  assign o_drop      = r_drop;

endmodule

// File: tb/tb_csidh_result_collector.sv
// Directed bench for csidh_result_collector: compare boundaries, latency, stalls,
// drops, output hold under back-pressure and mid-stream reset.
module tb_csidh_result_collector;

  localparam int unsigned N = 1024;
  localparam int unsigned W = 64;
  localparam int unsigned CHUNKS = N / W;

  // Test modulus with the CSIDH-1024 top word and distinct lower words
  localparam logic [N-1:0] P_TB = {
    64'h0ece55ed427012a9, 64'h8f3c2a1b5d6e7f01, 64'h1122334455667788, 64'h99aabbccddeeff00,
    64'h0123456789abcdef, 64'hfedcba9876543210, 64'h5a5a5a5a5a5a5a5a, 64'h3c3c3c3c3c3c3c3c,
    64'hdeadbeefcafef00d, 64'h7777777777777777, 64'h0f0f0f0f0f0f0f0f, 64'h8000000000000001,
    64'h2468ace013579bdf, 64'h6b8b4567327b23c6, 64'h643c986966334873, 64'hffffffffffff1a33
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         i_in_valid;
  logic [W-1:0] i_in_data;
  logic         i_invalid_in;
  logic         o_key_valid;
  logic         i_key_ready;
  logic [N-1:0] o_key_data;
  logic         o_key_err;
  logic         o_busy;
  logic         o_drop;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  csidh_result_collector #(.N(N), .W(W), .P(P_TB)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_in_valid   (i_in_valid),
    .i_in_data    (i_in_data),
    .i_invalid_in (i_invalid_in),
    .o_key_valid  (o_key_valid),
    .i_key_ready  (i_key_ready),
    .o_key_data   (o_key_data),
    .o_key_err    (o_key_err),
    .o_busy       (o_busy),
    .o_drop       (o_drop)
  );

  always #5 clk = ~clk;

  // Reports the most significant differing word so lines stay short
  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    int hi;
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      hi = 0;
      for (int i = 0; i < CHUNKS; i++)
        if (obs[i*W +: W] !== exp[i*W +: W]) hi = i;
      $display("FAIL %s: word %0d got %h expected %h", tag, hi, obs[hi*W +: W], exp[hi*W +: W]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Streams nbeats words LSW first; optional invalid beat and stall gaps after beats 4 and 10
  task automatic send_stream(input logic [N-1:0] v, input int inv_beat, input int gap_len,
                             input int nbeats);
    for (int i = 0; i < nbeats; i++) begin
      i_in_valid   = 1'b1;
      i_in_data    = v[i*W +: W];
      i_invalid_in = (i == inv_beat);
      step();
      if (gap_len > 0 && (i == 3 || i == 9)) begin
        i_in_valid   = 1'b0;
        i_invalid_in = 1'b0;
        i_in_data    = 64'hbad0bad0bad0bad0;
        repeat (gap_len) step();
      end
    end
    i_in_valid   = 1'b0;
    i_invalid_in = 1'b0;
    i_in_data    = '0;
  endtask

  task automatic wait_valid(output int c);
    c = 0;
    while (!o_key_valid && c < 200) begin
      step();
      c++;
    end
  endtask

  logic [N-1:0] val;
  logic [N-1:0] held_data;
  logic         held_err;
  int           c;
  int           t0;
  int           unstable;

  initial begin
    rst          = 1'b1;
    i_in_valid   = 1'b0;
    i_in_data    = '0;
    i_invalid_in = 1'b0;
    i_key_ready  = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_valid", N'(o_key_valid), N'(0));
    chk("rst_data",  o_key_data,      '0);
    chk("rst_err",   N'(o_key_err),   N'(0));
    chk("rst_busy",  N'(o_busy),      N'(0));
    chk("rst_drop",  N'(o_drop),      N'(0));

    // A = 1: latency, single-cycle valid with ready high
    val = N'(1);
    t0 = cyc;
    send_stream(val, -1, 0, CHUNKS);
    chk("one_busy", N'(o_busy), N'(1));
    chk("one_nodrop", N'(o_drop), N'(0));
    wait_valid(c);
    chk("one_latency", N'(c), N'(16));
    chk("one_valid", N'(o_key_valid), N'(1));
    chk("one_data", o_key_data, val);
    chk("one_err", N'(o_key_err), N'(0));
    step();
    chk("one_valid_drop", N'(o_key_valid), N'(0));
    chk("one_idle", N'(o_busy), N'(0));

    // A = P
    send_stream(P_TB, -1, 0, CHUNKS);
    wait_valid(c);
    chk("eqp_valid", N'(o_key_valid), N'(1));
    chk("eqp_data", o_key_data, P_TB);
    chk("eqp_err", N'(o_key_err), N'(1));
    step();

    // A = P-1: differs only in the lowest word
    val = P_TB - N'(1);
    send_stream(val, -1, 0, CHUNKS);
    wait_valid(c);
    chk("pm1_data", o_key_data, val);
    chk("pm1_err", N'(o_key_err), N'(0));
    step();

    // Top word of P plus one
    val = P_TB;
    val[N-1 -: W] = 64'h0ece55ed427012aa;
    send_stream(val, -1, 0, CHUNKS);
    wait_valid(c);
    chk("topp1_err", N'(o_key_err), N'(1));
    step();

    // Top word below P, every lower word all ones: still below P
    val = '1;
    val[N-1 -: W] = 64'h0ece55ed427012a8;
    send_stream(val, -1, 0, CHUNKS);
    wait_valid(c);
    chk("topm1_data", o_key_data, val);
    chk("topm1_err", N'(o_key_err), N'(0));
    step();

    // A = 0
    send_stream('0, -1, 0, CHUNKS);
    wait_valid(c);
    chk("zero_err", N'(o_key_err), N'(0));
    step();

    // Valid A, invalid flag only on beat 7 (index 6)
    val = P_TB - N'(1);
    send_stream(val, 6, 0, CHUNKS);
    wait_valid(c);
    chk("inv_data", o_key_data, val);
    chk("inv_err", N'(o_key_err), N'(1));
    step();

    // Two 3-cycle stalls add 6 cycles to the 32-cycle gapless total
    t0 = cyc;
    send_stream(val, -1, 3, CHUNKS);
    wait_valid(c);
    chk("gap_total", N'(cyc - t0), N'(38));
    chk("gap_data", o_key_data, val);
    chk("gap_err", N'(o_key_err), N'(0));
    step();

    // Extra beat during compare is dropped
    val = N'(1);
    send_stream(val, -1, 0, CHUNKS);
    i_in_valid = 1'b1;
    i_in_data  = '1;
    step();
    i_in_valid = 1'b0;
    i_in_data  = '0;
    chk("drop_pulse", N'(o_drop), N'(1));
    step();
    chk("drop_clear", N'(o_drop), N'(0));
    wait_valid(c);
    chk("drop_latency", N'(c), N'(14));
    chk("drop_data", o_key_data, val);
    chk("drop_err", N'(o_key_err), N'(0));
    step();

    // Back-pressure: result held for 20 cycles
    i_key_ready = 1'b0;
    val = P_TB - N'(1);
    send_stream(val, -1, 0, CHUNKS);
    wait_valid(c);
    held_data = o_key_data;
    held_err  = o_key_err;
    chk("hold_data0", held_data, val);
    unstable = 0;
    repeat (20) begin
      step();
      if (o_key_valid !== 1'b1 || o_key_data !== held_data || o_key_err !== held_err)
        unstable++;
    end
    chk("hold_stable", N'(unstable), N'(0));
    chk("hold_busy", N'(o_busy), N'(1));
    i_key_ready = 1'b1;
    step();
    chk("rel_valid", N'(o_key_valid), N'(0));
    chk("rel_busy", N'(o_busy), N'(0));
    chk("rel_keep", o_key_data, val);

    // Reset after beat 9 aborts collection
    send_stream(P_TB, -1, 0, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_valid", N'(o_key_valid), N'(0));
    chk("abort_busy", N'(o_busy), N'(0));
    chk("abort_data", o_key_data, '0);
    val = {CHUNKS{64'ha5a5a5a5a5a5a5a5}};
    send_stream(val, -1, 0, CHUNKS);
    wait_valid(c);
    chk("a5_latency", N'(c), N'(16));
    chk("a5_data", o_key_data, val);
    chk("a5_err", N'(o_key_err), N'(1));
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
